// File: rtl/seg_pkg.sv
// seg_pkg: shared FSM states and seven-segment patterns (bits 6..0 = segments a..g)
package seg_pkg;
  typedef enum logic [1:0] {IDLE, OWN, BLANK} state_e;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_OFF = 7'b0000000;
  localparam seg_t SEG_0 = 7'b1111110;
  localparam seg_t SEG_1 = 7'b0110000;
  localparam seg_t SEG_2 = 7'b1101101;
  localparam seg_t SEG_3 = 7'b1111001;
  localparam seg_t SEG_4 = 7'b0110011;
  localparam seg_t SEG_5 = 7'b1011011;
  localparam seg_t SEG_6 = 7'b1011111;
  localparam seg_t SEG_7 = 7'b1110000;
  localparam seg_t SEG_8 = 7'b1111111;
  localparam seg_t SEG_9 = 7'b1111011;
  localparam seg_t SEG_A = 7'b1110111;
  localparam seg_t SEG_B = 7'b0011111;
  localparam seg_t SEG_C = 7'b1001110;
  localparam seg_t SEG_D = 7'b0111101;
  localparam seg_t SEG_E = 7'b1001111;
  localparam seg_t SEG_F = 7'b1000111;
endpackage

// File: rtl/hex7seg_decoder.sv
// hex7seg_decoder: combinational hex nibble to active-high a..g segment pattern
module hex7seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);
  // one pattern per hex digit, lowercase b and d so they differ from 8 and 0
  always_comb begin
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin sharing of the two-digit display with minimum hold and digit scan
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int HOLD_CYC    = 4_194_304,
  parameter int REFRESH_CYC = 2048
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ*8-1:0] value_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic [7:0]         seven_seg_o
);
  localparam int OW = $clog2(N_REQ);
  localparam int HW = HOLD_CYC > 1 ? $clog2(HOLD_CYC) : 1;
  localparam int RW = REFRESH_CYC > 1 ? $clog2(REFRESH_CYC) : 1;
  state_e        state;
  logic [OW-1:0] owner, win;
  logic [HW-1:0] hold;
  logic [RW-1:0] refresh;
  logic          dig_sel, wrap, dig_next, hold_done, others, stay;
  logic [7:0]    own_val;
  seg_t          seg, dec;
  assign wrap      = refresh == RW'(REFRESH_CYC - 1);
  assign dig_next  = dig_sel ^ wrap;
  assign hold_done = hold == HW'(HOLD_CYC - 1);
  assign others    = |(req_i & ~(N_REQ'(1) << owner));
  assign stay      = req_i[owner] && !(hold_done && others);
  assign own_val   = 8'(value_i >> {owner, 3'b000});
  assign seven_seg_o = {seg, dig_sel};
  // decode the nibble for the digit that will be selected after this edge so segments and select stay aligned
  hex7seg_decoder u_dec (
    .nibble(dig_next ? own_val[7:4] : own_val[3:0]),
    .seg   (dec)
  );
  // round-robin pick: scan from farthest to nearest after the last owner so the nearest requester wins
  always_comb begin
    win = owner;
    for (int k = N_REQ; k >= 1; k--)
      if (req_i[OW'((int'(owner) + k) % N_REQ)]) win = OW'((int'(owner) + k) % N_REQ);
  end
  // free-running refresh counter; digit select flips on every wrap
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      refresh <= '0;
      dig_sel <= 1'b0;
    end else begin
      refresh <= wrap ? '0 : refresh + 1'b1;
      dig_sel <= dig_next;
    end
  end
  // ownership FSM with registered grant and segments; owner resets to the last index so requester 0 wins first
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      owner <= OW'(N_REQ - 1);
      hold  <= '0;
      gnt_o <= '0;
      seg   <= SEG_OFF;
    end else begin
      case (state)
        IDLE, BLANK: begin
          state <= IDLE;
          if (|req_i) begin
            state <= OWN;
            owner <= win;
            hold  <= '0;
            gnt_o <= N_REQ'(1) << win;
          end
        end
        OWN: begin
          hold <= hold_done ? hold : hold + 1'b1;
          if (!stay) begin
            state <= BLANK;
            gnt_o <= '0;
          end
        end
        default: begin
          state <= IDLE;
          gnt_o <= '0;
        end
      endcase
      seg <= (state == OWN && stay) ? dec : SEG_OFF;
    end
  end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: directed scenarios plus random traffic checked against a cycle-level ownership model
module tb_seg_display_arbiter;
  localparam int N = 2, H = 8, R = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0, gnt;
  logic [N*8-1:0] val = '0;
  logic [7:0] sevseg;
  int passed = 0, total = 0;
  int m_own = -1, m_last = N - 1, m_held = 0, m_t = 0;
  bit m_blank = 1'b0;
  logic [6:0] m_seg = '0;
  logic [6:0] pat [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  seg_display_arbiter #(.N_REQ(N), .HOLD_CYC(H), .REFRESH_CYC(R)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .value_i(val),
    .gnt_o(gnt), .seven_seg_o(sevseg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
  endtask

  // nearest pending requester after the last owner takes the display
  task automatic grant();
    for (int k = 1; k <= N; k++) begin
      int i = (m_last + k) % N;
      if (m_own < 0 && req[i]) begin
        m_own = i;
        m_last = i;
        m_held = 1;
      end
    end
  endtask

  // advance the model over one rising edge using the inputs sampled at that edge
  task automatic model_edge();
    int prev;
    logic [7:0] v;
    int dig;
    if (!rst_n) begin
      m_own = -1; m_blank = 0; m_last = N - 1; m_held = 0; m_t = 0; m_seg = '0;
      return;
    end
    prev = m_own;
    v = (prev >= 0) ? 8'(val >> (8 * prev)) : 8'h00;
    m_t++;
    if (m_own >= 0) begin
      if (!req[m_own] || (m_held >= H && (req & ~(N'(1) << m_own)) != 0)) begin
        m_own = -1;
        m_blank = 1;
      end else m_held++;
    end else if (m_blank) begin
      m_blank = 0;
      grant();
    end else grant();
    dig = (m_t / R) % 2;
    m_seg = (prev >= 0 && m_own == prev) ? pat[dig ? v[7:4] : v[3:0]] : 7'b0;
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("gnt", 8'(gnt), 8'(m_own >= 0 ? (1 << m_own) : 0));
      chk("seg", sevseg, {m_seg, 1'((m_t / R) % 2)});
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b11; val = 16'($urandom);
    cyc(3);
    chk("rst_gnt", 8'(gnt), 8'h00);
    chk("rst_seg", sevseg, 8'h00);
    rst_n = 1'b1; req = 2'b00;
    cyc(10);
    // single requester showing 0x3A
    val = 16'h003A; req = 2'b01;
    cyc(1);
    chk("single_gnt", 8'(gnt), 8'h01);
    cyc(12);
    req = 2'b00;
    cyc(3);
    // preemption after the hold time
    req = 2'b01;
    cyc(2);
    req = 2'b11;
    cyc(12);
    req = 2'b00;
    cyc(3);
    // owner releases early while requester 1 waits
    req = 2'b01;
    cyc(3);
    req = 2'b10;
    cyc(4);
    // fairness under constant contention
    req = 2'b11;
    val = 16'hC75E;
    cyc(40);
    // reset during ownership of requester 1
    for (int i = 0; i < 20 && gnt !== 2'b10; i++) cyc(1);
    chk("wait_own1", 8'(gnt), 8'h02);
    rst_n = 1'b0;
    cyc(1);
    chk("midrst_gnt", 8'(gnt), 8'h00);
    rst_n = 1'b1; req = 2'b11;
    cyc(1);
    chk("midrst_win", 8'(gnt), 8'h01);
    // random traffic with sticky requests and changing values
    repeat (400) begin
      if ($urandom_range(0, 7) == 0) req = 2'($urandom);
      val = 16'($urandom);
      cyc(1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
